// File: rtl/router_pkt_tx_pkg.sv
// Shared types and constants for the router packet transmitter.
// Imported by the buffer, the interface users and the top level.
package router_pkt_tx_pkg;

   localparam logic [5:0] MAX_LEN      = 6'd63;
   localparam logic [1:0] ADDR_ILLEGAL = 2'b11;
   localparam logic [1:0] GAP_CYCLES   = 2'd2;

   typedef enum logic [2:0] {
      StIdle,
      StFill,
      StHdr,
      StPld,
      StPar,
      StGap
   } tx_state_e;

   function automatic logic [7:0] hdr_byte(input logic [5:0] len, input logic [1:0] addr);
      return {len, addr};
   endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Upstream command/payload and downstream router byte signals of the transmitter.
// The DUT side uses the slave modport, the driving environment the master modport.
interface router_pkt_tx_if;

   logic       start;
   logic [1:0] addr;
   logic [5:0] len;
   logic       corrupt;
   logic [7:0] src_data;
   logic       src_valid;
   logic       src_ready;
   logic       busy;
   logic       pkt_valid;
   logic [7:0] pkt_data;
   logic       tx_busy;
   logic       done;
   logic       cfg_err;

   modport master (
      output start, addr, len, corrupt, src_data, src_valid, busy,
      input  src_ready, pkt_valid, pkt_data, tx_busy, done, cfg_err
   );

   modport slave (
      input  start, addr, len, corrupt, src_data, src_valid, busy,
      output src_ready, pkt_valid, pkt_data, tx_busy, done, cfg_err
   );

endinterface

// File: rtl/router_tx_buf.sv
// 63x8 payload byte buffer: synchronous write, combinational read at the read pointer.
// Both pointers restart at zero on i_clr so each packet fills from entry 0.
module router_tx_buf
   import router_pkt_tx_pkg::*;
(
   input  logic       i_clock,
   input  logic       i_resetn,
   input  logic       i_clr,
   input  logic       i_wr_en,
   input  logic [7:0] i_wr_data,
   input  logic       i_rd_en,
   output logic [7:0] o_rd_data,
   output logic [5:0] o_wr_ptr
);

   logic [7:0] r_mem [0:MAX_LEN-1];
   logic [5:0] r_wr_ptr;
   logic [5:0] r_rd_ptr;

   always_ff @(posedge i_clock) begin
      if (i_wr_en && (r_wr_ptr < MAX_LEN)) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_wr_en) r_wr_ptr <= r_wr_ptr + 6'd1;
         if (i_rd_en) r_rd_ptr <= r_rd_ptr + 6'd1;
      end
   end

   // A full 63-byte packet leaves the read pointer one past the last entry.
   assign o_rd_data = (r_rd_ptr < MAX_LEN) ? r_mem[r_rd_ptr] : 8'h00;
   assign o_wr_ptr  = r_wr_ptr;

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload, then sends header, payload and parity
// to the router byte by byte, honouring the router's busy stall.
module router_pkt_tx
   import router_pkt_tx_pkg::*;
(
   input  logic            i_clock,
   input  logic            i_resetn,
   router_pkt_tx_if.slave  io_tx
);

   tx_state_e  r_state;
   logic [1:0] r_addr;
   logic [5:0] r_len;
   logic       r_corrupt;
   logic [5:0] r_idx;
   logic [7:0] r_parity;
   logic [1:0] r_gap;
   logic       r_src_ready;
   logic       r_pkt_valid;
   logic [7:0] r_pkt_data;
   logic       r_tx_busy;
   logic       r_done;
   logic       r_cfg_err;

   logic       w_start_legal;
   logic       w_buf_clr;
   logic       w_wr_en;
   logic       w_last_wr;
   logic       w_pld_last;
   logic       w_rd_en;
   logic [7:0] w_rd_data;
   logic [5:0] w_wr_ptr;
   logic [7:0] w_hdr;

   assign w_start_legal = io_tx.start && (io_tx.addr != ADDR_ILLEGAL) && (io_tx.len != 6'd0);
   assign w_buf_clr     = (r_state == StIdle) && w_start_legal;
   assign w_wr_en       = (r_state == StFill) && io_tx.src_valid && r_src_ready;
   assign w_last_wr     = w_wr_en && (w_wr_ptr == r_len - 6'd1);
   assign w_pld_last    = (r_idx == r_len - 6'd1);
   // Prefetch the next payload byte as the current one is consumed.
   assign w_rd_en       = !io_tx.busy &&
                          ((r_state == StHdr) || ((r_state == StPld) && !w_pld_last));
   assign w_hdr         = hdr_byte(r_len, r_addr);

   router_tx_buf u_buf (
      .i_clock   (i_clock),
      .i_resetn  (i_resetn),
      .i_clr     (w_buf_clr),
      .i_wr_en   (w_wr_en),
      .i_wr_data (io_tx.src_data),
      .i_rd_en   (w_rd_en),
      .o_rd_data (w_rd_data),
      .o_wr_ptr  (w_wr_ptr)
   );

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state     <= StIdle;
         r_addr      <= '0;
         r_len       <= '0;
         r_corrupt   <= 1'b0;
         r_idx       <= '0;
         r_parity    <= '0;
         r_gap       <= '0;
         r_src_ready <= 1'b0;
         r_pkt_valid <= 1'b0;
         r_pkt_data  <= '0;
         r_tx_busy   <= 1'b0;
         r_done      <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
         case (r_state)
            StIdle: begin
               if (io_tx.start) begin
                  if (w_start_legal) begin
                     r_addr      <= io_tx.addr;
                     r_len       <= io_tx.len;
                     r_corrupt   <= io_tx.corrupt;
                     r_idx       <= '0;
                     r_parity    <= '0;
                     r_gap       <= '0;
                     r_src_ready <= 1'b1;
                     r_tx_busy   <= 1'b1;
                     r_state     <= StFill;
                  end else begin
                     r_cfg_err <= 1'b1;
                  end
               end
            end
            StFill: begin
               if (w_wr_en) begin
                  if (w_last_wr) begin
                     r_parity    <= r_parity ^ io_tx.src_data ^ w_hdr;
                     r_src_ready <= 1'b0;
                     r_pkt_valid <= 1'b1;
                     r_pkt_data  <= w_hdr;
                     r_state     <= StHdr;
                  end else begin
                     r_parity <= r_parity ^ io_tx.src_data;
                  end
               end
            end
            StHdr: begin
               if (!io_tx.busy) begin
                  r_pkt_data <= w_rd_data;
                  r_idx      <= '0;
                  r_state    <= StPld;
               end
            end
            StPld: begin
               if (!io_tx.busy) begin
                  if (w_pld_last) begin
                     r_pkt_valid <= 1'b0;
                     r_pkt_data  <= r_corrupt ? ~r_parity : r_parity;
                     r_state     <= StPar;
                  end else begin
                     r_idx      <= r_idx + 6'd1;
                     r_pkt_data <= w_rd_data;
                  end
               end
            end
            StPar: begin
               if (!io_tx.busy) begin
                  r_pkt_data <= '0;
                  r_done     <= 1'b1;
                  r_gap      <= '0;
                  r_state    <= StGap;
               end
            end
            StGap: begin
               if (r_gap == GAP_CYCLES - 2'd1) begin
                  r_tx_busy <= 1'b0;
                  r_state   <= StIdle;
               end else begin
                  r_gap <= r_gap + 2'd1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign io_tx.src_ready = r_src_ready;
   assign io_tx.pkt_valid = r_pkt_valid;
   assign io_tx.pkt_data  = r_pkt_data;
   assign io_tx.tx_busy   = r_tx_busy;
   assign io_tx.done      = r_done;
   assign io_tx.cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: a packet-level model predicts every output each cycle,
// and directed packets are pinned against hand-computed byte streams.
module tb_router_pkt_tx;

   logic clock = 1'b0;
   logic resetn;
   always #5 clock = ~clock;

   router_pkt_tx_if ifc ();

   router_pkt_tx dut (
      .i_clock  (clock),
      .i_resetn (resetn),
      .io_tx    (ifc)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Packet-level model: 0 idle, 1 filling, 2 sending, 3 gap.
   int         m_phase = 0;
   logic [1:0] m_addr;
   logic [5:0] m_len;
   logic       m_corrupt;
   logic [7:0] m_pay [$];
   logic [8:0] exp_q [$];
   logic [8:0] m_head;
   logic [7:0] m_par;
   logic [7:0] m_hdr;
   bit         m_done = 0;
   bit         m_err = 0;
   int         m_gap = 0;
   logic [7:0] seen [$];

   always @(negedge clock) begin
      if (!resetn) begin
         m_phase = 0;
         m_done  = 0;
         m_err   = 0;
         exp_q.delete();
         m_pay.delete();
      end else begin
         chk("src_ready", ifc.src_ready, m_phase == 1);
         chk("tx_busy", ifc.tx_busy, m_phase != 0);
         chk("done", ifc.done, m_done);
         chk("cfg_err", ifc.cfg_err, m_err);
         if (m_phase == 2 && exp_q.size() > 0) begin
            m_head = exp_q[0];
            chk("pkt_valid", ifc.pkt_valid, m_head[8]);
            chk("pkt_data", ifc.pkt_data, m_head[7:0]);
         end else begin
            chk("pkt_valid_idle", ifc.pkt_valid, 0);
            chk("pkt_data_idle", ifc.pkt_data, 0);
         end
         m_done = 0;
         m_err  = 0;
         case (m_phase)
            0: if (ifc.start) begin
               if (ifc.addr == 2'd3 || ifc.len == 6'd0) begin
                  m_err = 1;
               end else begin
                  m_addr    = ifc.addr;
                  m_len     = ifc.len;
                  m_corrupt = ifc.corrupt;
                  m_pay.delete();
                  m_phase   = 1;
               end
            end
            1: if (ifc.src_valid) begin
               m_pay.push_back(ifc.src_data);
               if (m_pay.size() == int'(m_len)) begin
                  m_hdr = {m_len, m_addr};
                  m_par = m_hdr;
                  exp_q.delete();
                  exp_q.push_back({1'b1, m_hdr});
                  foreach (m_pay[k]) begin
                     exp_q.push_back({1'b1, m_pay[k]});
                     m_par = m_par ^ m_pay[k];
                  end
                  if (m_corrupt) m_par = ~m_par;
                  exp_q.push_back({1'b0, m_par});
                  m_phase = 2;
               end
            end
            2: if (!ifc.busy) begin
               seen.push_back(ifc.pkt_data);
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) begin
                  m_done  = 1;
                  m_phase = 3;
                  m_gap   = 2;
               end
            end
            default: begin
               m_gap--;
               if (m_gap == 0) m_phase = 0;
            end
         endcase
      end
   end

   logic [7:0] pay [64];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start(input logic [1:0] a, input logic [5:0] l, input logic c);
      ifc.start   = 1'b1;
      ifc.addr    = a;
      ifc.len     = l;
      ifc.corrupt = c;
      tick();
      // Scramble the command fields to show they were latched.
      ifc.start   = 1'b0;
      ifc.addr    = ~a;
      ifc.len     = ~l;
      ifc.corrupt = ~c;
   endtask

   task automatic fill(input int l, input bit toggle);
      int i = 0;
      int budget = 0;
      bit taken;
      while (i < l && budget < 400) begin
         ifc.src_valid = toggle ? budget[0] : 1'b1;
         ifc.src_data  = ifc.src_valid ? pay[i] : 8'h00;
         @(negedge clock);
         taken = ifc.src_valid && ifc.src_ready;
         tick();
         if (taken) i++;
         budget++;
      end
      ifc.src_valid = 1'b0;
      ifc.src_data  = 8'h00;
      if (i < l) chk("fill_timeout", i, l);
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!ifc.done && n < 300);
      if (!ifc.done) chk("done_timeout", 0, 1);
   endtask

   task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input logic c,
                          input bit toggle, input int busy_hdr, input logic [7:0] exp_hdr);
      seen.delete();
      do_start(a, l, c);
      fill(int'(l), toggle);
      if (busy_hdr > 0) begin
         ifc.busy = 1'b1;
         for (int k = 0; k < busy_hdr; k++) begin
            @(negedge clock);
            chk("hdr_hold", {ifc.pkt_valid, ifc.pkt_data}, {1'b1, exp_hdr});
            tick();
         end
         ifc.busy = 1'b0;
      end
      @(negedge clock);
      chk("hdr_present", {ifc.pkt_valid, ifc.pkt_data}, {1'b1, exp_hdr});
      wait_done();
   endtask

   task automatic chk_seen(input string name, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
      logic [7:0] e [5];
      e = '{e0, e1, e2, e3, e4};
      chk({name, "_len"}, seen.size(), 5);
      for (int k = 0; k < 5 && k < seen.size(); k++) chk(name, seen[k], e[k]);
   endtask

   initial begin
      ifc.start = 0; ifc.addr = 0; ifc.len = 0; ifc.corrupt = 0;
      ifc.src_data = 0; ifc.src_valid = 0; ifc.busy = 0;
      resetn = 1'b0;
      #12;
      chk("rst_outputs", {ifc.pkt_valid, ifc.pkt_data, ifc.src_ready, ifc.tx_busy,
                          ifc.done, ifc.cfg_err}, 0);
      @(posedge clock);
      #2 resetn = 1'b1;
      tick();

      pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'hFF;
      run_pkt(2'd1, 6'd3, 1'b0, 1'b0, 0, 8'h0D);
      chk_seen("basic", 8'h0D, 8'hA5, 8'h3C, 8'hFF, 8'h6B);
      repeat (3) tick();

      run_pkt(2'd1, 6'd3, 1'b1, 1'b0, 0, 8'h0D);
      chk_seen("corrupt", 8'h0D, 8'hA5, 8'h3C, 8'hFF, 8'h94);
      repeat (3) tick();

      run_pkt(2'd1, 6'd3, 1'b0, 1'b0, 3, 8'h0D);
      chk_seen("busy_hdr", 8'h0D, 8'hA5, 8'h3C, 8'hFF, 8'h6B);
      repeat (3) tick();

      ifc.start = 1'b1; ifc.addr = 2'd3; ifc.len = 6'd5;
      tick();
      ifc.start = 1'b0;
      @(negedge clock);
      chk("bad_addr", {ifc.cfg_err, ifc.tx_busy, ifc.pkt_valid}, 3'b100);
      tick();
      ifc.start = 1'b1; ifc.addr = 2'd0; ifc.len = 6'd0;
      tick();
      ifc.start = 1'b0;
      @(negedge clock);
      chk("bad_len", {ifc.cfg_err, ifc.tx_busy, ifc.pkt_valid}, 3'b100);
      tick();

      for (int k = 0; k < 63; k++) pay[k] = 8'(k * 37 + 11);
      run_pkt(2'd2, 6'd63, 1'b0, 1'b1, 0, 8'hFE);
      chk("long_count", seen.size(), 65);
      if (seen.size() == 65) begin
         chk("long_hdr", seen[0], 8'hFE);
         chk("long_first", seen[1], 8'h0B);
         chk("long_last", seen[63], 8'(62 * 37 + 11));
      end

      // Start during the second gap cycle must be ignored.
      tick();
      ifc.start = 1'b1; ifc.addr = 2'd0; ifc.len = 6'd3; ifc.corrupt = 1'b0;
      tick();
      ifc.start = 1'b0;
      @(negedge clock);
      chk("gap_ignore", {ifc.tx_busy, ifc.src_ready}, 2'b00);
      tick();

      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
      do_start(2'd0, 6'd3, 1'b0);
      fill(3, 1'b0);
      tick();
      #1 resetn = 1'b0;
      #1;
      chk("rst_async", {ifc.pkt_valid, ifc.pkt_data, ifc.src_ready, ifc.tx_busy,
                        ifc.done, ifc.cfg_err}, 0);
      tick();
      tick();
      #1 resetn = 1'b1;
      tick();

      pay[0] = 8'h5A;
      seen.delete();
      run_pkt(2'd0, 6'd1, 1'b0, 1'b0, 0, 8'h04);
      chk("post_rst_len", seen.size(), 3);
      if (seen.size() == 3) begin
         chk("post_rst_hdr", seen[0], 8'h04);
         chk("post_rst_pld", seen[1], 8'h5A);
         chk("post_rst_par", seen[2], 8'h5E);
      end
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
